// File: rtl/auto_whacker.sv
// auto_whacker: attract/demo-mode player. Watches the mole bitmap and, after a
// programmable reaction delay, toggles the matching emulated switch so that hit
// logic registers a whack. With enable low the physical switches pass straight through.
module auto_whacker #(
  parameter int NUM_HOLES     = 17,
  parameter int CLKS_PER_MS   = 50000,
  parameter int REACTION_MS   = 250,
  parameter int COOLDOWN_CLKS = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 game_in_progress,
  input  logic [NUM_HOLES-1:0] mole_positions,
  input  logic [NUM_HOLES-1:0] switches_in,
  output logic [NUM_HOLES-1:0] switches_out,
  output logic                 busy,
  output logic [4:0]           target_idx,
  output logic [15:0]          whack_count
);

  localparam int REACT_CLKS = REACTION_MS * CLKS_PER_MS;
  localparam int MAX_CLKS   = (REACT_CLKS > COOLDOWN_CLKS) ? REACT_CLKS : COOLDOWN_CLKS;
  localparam int CNT_W      = $clog2(MAX_CLKS + 1);

  localparam logic [CNT_W-1:0]     REACT_LOAD   = CNT_W'(REACT_CLKS - 1);
  localparam logic [CNT_W-1:0]     COOL_LOAD    = (COOLDOWN_CLKS > 0) ? CNT_W'(COOLDOWN_CLKS - 1) : CNT_W'(0);
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ZERO     = CNT_W'(0);
  localparam logic [NUM_HOLES-1:0] HOLE0        = NUM_HOLES'(1);
  localparam bit                   HAS_COOLDOWN = (COOLDOWN_CLKS > 0);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_AIM      = 2'd1;
  localparam logic [1:0] ST_STRIKE   = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  // Lowest set index of a hole vector; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [NUM_HOLES-1:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_dly;
  logic [4:0]           r_target;
  logic [NUM_HOLES-1:0] r_pending;
  logic [NUM_HOLES-1:0] r_mole_prev;
  logic [NUM_HOLES-1:0] r_sw_state;
  logic [15:0]          r_whack;
  logic                 r_busy;
  logic                 r_en_prev;

  logic                 w_active;
  logic [NUM_HOLES-1:0] w_rise;
  logic [NUM_HOLES-1:0] w_strike_mask;
  logic [NUM_HOLES-1:0] w_pending_next;
  logic [1:0]           w_next_state;
  logic [CNT_W-1:0]     w_next_dly;
  logic [4:0]           w_next_target;
  logic                 w_strike;

  assign w_active = enable & game_in_progress;

  // Emulated bank only reaches hit logic when enabled and out of reset.
  assign switches_out = (rst_n && enable) ? r_sw_state : switches_in;
  assign busy         = r_busy;
  assign target_idx   = r_target;
  assign whack_count  = r_whack;

  // Pending-mole bookkeeping: latch rising moles, drop fallen/struck ones, flush when inactive.
  always_comb begin
    w_rise        = mole_positions & ~r_mole_prev;
    w_strike_mask = w_strike ? (HOLE0 << r_target) : '0;
    if (w_active) begin
      w_pending_next = (r_pending | w_rise) & mole_positions & ~w_strike_mask;
    end else begin
      w_pending_next = '0;
    end
  end

  // Next-state logic for the IDLE/AIM/STRIKE/COOLDOWN sequencer.
  always_comb begin
    w_next_state  = r_state;
    w_next_dly    = r_dly;
    w_next_target = r_target;
    w_strike      = 1'b0;
    if (!w_active) begin
      w_next_state  = ST_IDLE;
      w_next_dly    = CNT_ZERO;
      w_next_target = 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            w_next_state  = ST_AIM;
            w_next_target = lowest_set(r_pending);
            w_next_dly    = REACT_LOAD;
          end else begin
            w_next_target = 5'd0;
          end
        end
        ST_AIM: begin
          // A dropped mole abandons the shot even if the delay expires this cycle.
          if (!mole_positions[r_target]) begin
            w_next_state  = ST_IDLE;
            w_next_target = 5'd0;
          end else if (r_dly == CNT_ZERO) begin
            w_next_state = ST_STRIKE;
          end else begin
            w_next_dly = r_dly - CNT_ONE;
          end
        end
        ST_STRIKE: begin
          w_strike = 1'b1;
          if (HAS_COOLDOWN) begin
            w_next_state = ST_COOLDOWN;
            w_next_dly   = COOL_LOAD;
          end else begin
            w_next_state  = ST_IDLE;
            w_next_target = 5'd0;
          end
        end
        ST_COOLDOWN: begin
          if (r_dly == CNT_ZERO) begin
            w_next_state  = ST_IDLE;
            w_next_target = 5'd0;
          end else begin
            w_next_dly = r_dly - CNT_ONE;
          end
        end
        default: begin
          w_next_state  = ST_IDLE;
          w_next_dly    = CNT_ZERO;
          w_next_target = 5'd0;
        end
      endcase
    end
  end

  // State, counters and mole history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dly       <= CNT_ZERO;
      r_target    <= 5'd0;
      r_pending   <= '0;
      r_mole_prev <= '0;
      r_busy      <= 1'b0;
      r_en_prev   <= 1'b0;
      r_whack     <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_dly       <= w_next_dly;
      r_target    <= w_next_target;
      r_pending   <= w_pending_next;
      r_mole_prev <= mole_positions;
      r_busy      <= (w_next_state != ST_IDLE);
      r_en_prev   <= enable;
      if (w_strike && (r_whack != 16'hFFFF)) begin
        r_whack <= r_whack + 16'd1;
      end else begin
        r_whack <= r_whack;
      end
    end
  end

  // Emulated switch bank: shadows the physical bank while disabled and on the
  // enable handover cycle, so taking over never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_state <= '0;
    end else if (!enable || !r_en_prev) begin
      r_sw_state <= switches_in;
    end else if (w_strike) begin
      r_sw_state <= r_sw_state ^ w_strike_mask;
    end else begin
      r_sw_state <= r_sw_state;
    end
  end

endmodule

// File: tb/tb_auto_whacker.sv
// Self-checking bench for auto_whacker: directed scenarios plus randomized play,
// every cycle compared against a timestamp-based reference model.
module tb_auto_whacker;

  localparam int NH  = 17;
  localparam int CPM = 2;
  localparam int RMS = 3;
  localparam int CD  = 4;
  localparam int RC  = RMS * CPM;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          game_in_progress;
  logic [NH-1:0] mole_positions;
  logic [NH-1:0] switches_in;
  logic [NH-1:0] switches_out;
  logic          busy;
  logic [4:0]    target_idx;
  logic [15:0]   whack_count;

  int n_checks;
  int n_errors;

  auto_whacker #(
    .NUM_HOLES(NH), .CLKS_PER_MS(CPM), .REACTION_MS(RMS), .COOLDOWN_CLKS(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .game_in_progress(game_in_progress),
    .mole_positions(mole_positions), .switches_in(switches_in),
    .switches_out(switches_out), .busy(busy), .target_idx(target_idx),
    .whack_count(whack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (absolute-time bookkeeping) ----------------
  int          n_edge;
  logic [NH-1:0] m_pend;
  logic [NH-1:0] m_prev;
  logic [NH-1:0] m_sw;
  logic        m_en_prev;
  int          m_tgt;       // hole being aimed at, -1 when none
  int          m_aim_at;    // edge at which aiming started
  int          m_cool_end;  // busy through edges strictly before this one
  int          m_cool_tgt;
  int unsigned m_count;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_sw = '0; m_en_prev = 1'b0;
    m_tgt = -1; m_aim_at = 0; m_cool_end = 0; m_cool_tgt = 0; m_count = 0;
  endtask

  task automatic model_step();
    logic [NH-1:0] struck;
    bit active;
    int elapsed;
    n_edge++;
    struck = '0;
    active = enable && game_in_progress;
    if (!active) begin
      m_tgt = -1;
      m_cool_end = 0;
    end else if (m_tgt >= 0) begin
      elapsed = n_edge - m_aim_at;
      if (elapsed <= RC) begin
        if (!mole_positions[m_tgt]) m_tgt = -1;
      end else begin
        struck[m_tgt] = 1'b1;
        if (m_count < 65535) m_count++;
        m_cool_tgt = m_tgt;
        m_cool_end = n_edge + CD;
        m_tgt = -1;
      end
    end else if (n_edge > m_cool_end && m_pend != '0) begin
      for (int i = NH - 1; i >= 0; i--) if (m_pend[i]) m_tgt = i;
      m_aim_at = n_edge;
    end
    if (!enable || !m_en_prev) m_sw = switches_in;
    else m_sw = m_sw ^ struck;
    if (active) m_pend = (m_pend | (mole_positions & ~m_prev)) & mole_positions & ~struck;
    else m_pend = '0;
    m_prev = mole_positions;
    m_en_prev = enable;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check the passthrough mux, clock, then check the registered outputs.
  task automatic step();
    int exp_tgt;
    bit exp_busy;
    #1;
    check_eq("sw_out", 32'(switches_out), 32'(enable ? m_sw : switches_in));
    @(posedge clk);
    model_step();
    #1;
    exp_busy = (m_tgt >= 0) || (n_edge < m_cool_end);
    exp_tgt  = (m_tgt >= 0) ? m_tgt : ((n_edge < m_cool_end) ? m_cool_tgt : 0);
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("target_idx", 32'(target_idx), 32'(exp_tgt));
    check_eq("whack_count", 32'(whack_count), 32'(m_count));
  endtask

  initial begin
    logic [NH-1:0] prev_out;
    logic [NH-1:0] diff;
    int first_hole;
    int second_hole;
    int idx;
    n_checks = 0; n_errors = 0; n_edge = 0;
    model_reset();

    // Reset state, with enable high to prove the emulated path stays dead in reset.
    rst_n = 1'b0; enable = 1'b1; game_in_progress = 1'b1;
    mole_positions = '0; switches_in = 17'h15A5A;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_target", 32'(target_idx), 32'd0);
    check_eq("rst_whacks", 32'(whack_count), 32'd0);
    check_eq("rst_pass", 32'(switches_out), 32'h15A5A);
    enable = 1'b0; switches_in = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_step();

    // Single mole: reaction latency, count, cooldown length.
    enable = 1'b1; game_in_progress = 1'b1;
    repeat (3) step();
    mole_positions[5] = 1'b1;
    step();                       // pending latched
    step();                       // aiming
    check_eq("t2_aim_tgt", 32'(target_idx), 32'd5);
    check_eq("t2_aim_busy", 32'(busy), 32'd1);
    repeat (6) step();
    check_eq("t2_no_early", 32'(switches_out[5]), 32'd0);
    step();
    check_eq("t2_toggle", 32'(switches_out[5]), 32'd1);
    check_eq("t2_count", 32'(whack_count), 32'd1);
    repeat (3) step();
    check_eq("t2_cool_busy", 32'(busy), 32'd1);
    step();
    check_eq("t2_cool_done", 32'(busy), 32'd0);

    // Two moles rise together: lowest index first.
    mole_positions = '0;
    repeat (2) step();
    mole_positions[2] = 1'b1; mole_positions[9] = 1'b1;
    first_hole = -1; second_hole = -1; prev_out = switches_out;
    for (int k = 0; k < 60; k++) begin
      step();
      diff = switches_out ^ prev_out;
      prev_out = switches_out;
      if (diff != '0) begin
        idx = -1;
        for (int i = NH - 1; i >= 0; i--) if (diff[i]) idx = i;
        if (first_hole < 0) first_hole = idx;
        else if (second_hole < 0) second_hole = idx;
      end
    end
    check_eq("t3_first", 32'(first_hole), 32'd2);
    check_eq("t3_second", 32'(second_hole), 32'd9);
    check_eq("t3_count", 32'(whack_count), 32'd3);

    // Mole drops mid-aim: shot abandoned.
    mole_positions = '0;
    repeat (2) step();
    mole_positions[3] = 1'b1;
    step(); step();
    repeat (3) step();
    mole_positions[3] = 1'b0;
    step();
    check_eq("t4_abandon_busy", 32'(busy), 32'd0);
    check_eq("t4_abandon_tgt", 32'(target_idx), 32'd0);
    repeat (12) step();
    check_eq("t4_no_toggle", 32'(switches_out[3]), 32'd0);
    check_eq("t4_count", 32'(whack_count), 32'd3);

    // Passthrough and glitch-free handover.
    enable = 1'b0; switches_in = 17'h0A5A5;
    repeat (2) step();
    check_eq("t5_pass", 32'(switches_out), 32'h0A5A5);
    enable = 1'b1;
    #1;
    check_eq("t5_handover", 32'(switches_out), 32'h0A5A5);
    step();
    check_eq("t5_after", 32'(switches_out), 32'h0A5A5);

    // Game ends during cooldown with moles still pending.
    mole_positions = '0;
    mole_positions[1] = 1'b1; mole_positions[7] = 1'b1; mole_positions[11] = 1'b1;
    for (int k = 0; k < 40 && whack_count != 16'd4; k++) step();
    check_eq("t6_strike", 32'(whack_count), 32'd4);
    step();
    check_eq("t6_cool_busy", 32'(busy), 32'd1);
    game_in_progress = 1'b0;
    step();
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    check_eq("t6_idle_tgt", 32'(target_idx), 32'd0);
    repeat (20) step();
    game_in_progress = 1'b1;
    repeat (20) step();
    check_eq("t6_count", 32'(whack_count), 32'd4);
    check_eq("t6_sw", 32'(switches_out), 32'h0A5A7);

    // Asynchronous reset in the middle of an aim.
    mole_positions = '0;
    step();
    switches_in = 17'h12345;
    mole_positions[4] = 1'b1;
    repeat (4) step();
    check_eq("t1_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_whacks", 32'(whack_count), 32'd0);
    check_eq("t1_pass", 32'(switches_out), 32'h12345);
    model_reset();
    @(posedge clk); #3;
    check_eq("t1_hold_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_step();

    // Randomized play.
    enable = 1'b1; game_in_progress = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, NH - 1));
        mole_positions[idx] = ~mole_positions[idx];
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 79) == 0) game_in_progress = ~game_in_progress;
      if ($urandom_range(0, 7) == 0) switches_in = NH'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
